// File: rtl/cpu_reg_pkg.sv
// Shared definitions for the general/special register file: default sizes,
// special-register offsets and the special-register address mapping.
package cpu_reg_pkg;

   localparam int GPR_NUM_DEF  = 8;
   localparam int SPR_NUM_DEF  = 4;
   localparam int PEND_MAX_DEF = 3;

   // Special registers are offsets from the first address past the GPRs.
   localparam int SPR_SP    = 0;
   localparam int SPR_IH    = 1;
   localparam int SPR_T     = 2;
   localparam int SPR_SPARE = 3;

   function automatic int spr_addr(input int idx);
      return GPR_NUM_DEF + idx;
   endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down pending-write counter for one register; 1-cycle update.
// Simultaneous inc and dec cancel; inc at MAX and dec at 0 both hold.
module pend_counter #(
   parameter int MAX = 3,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic [CW-1:0] cnt_o,
   output logic          full_o
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && cnt_q != MAX_C) begin
         cnt_d = cnt_q + ONE_C;
      end else if (dec_i && !inc_i && cnt_q != '0) begin
         cnt_d = cnt_q - ONE_C;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign full_o = (cnt_q == MAX_C);

endmodule

// File: rtl/reg_file_scoreboard.sv
// Unified GPR/SPR register file with two bypassed combinational read ports and
// a per-register pending-write scoreboard for RAW hazard detection at decode.
module reg_file_scoreboard
   import cpu_reg_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int GPR_NUM  = GPR_NUM_DEF,
   parameter  int SPR_NUM  = SPR_NUM_DEF,
   parameter  int PEND_MAX = PEND_MAX_DEF,
   localparam int REG_NUM  = GPR_NUM + SPR_NUM,
   localparam int AW       = $clog2(REG_NUM),
   localparam int CW       = $clog2(PEND_MAX + 1)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [AW-1:0]             rdAddr1,
   input  logic [AW-1:0]             rdAddr2,
   output logic [DATA_W-1:0]         rdData1,
   output logic [DATA_W-1:0]         rdData2,
   output logic                      rdBusy1,
   output logic                      rdBusy2,
   input  logic                      claimEn,
   input  logic [AW-1:0]             claimAddr,
   output logic                      claimErr,
   input  logic                      wrEn,
   input  logic [AW-1:0]             wrAddr,
   input  logic [DATA_W-1:0]         wrData,
   input  logic                      wrRelease,
   output logic [REG_NUM*DATA_W-1:0] dumpData
);

   localparam logic [AW:0]   REG_NUM_W = (AW + 1)'(REG_NUM);
   localparam logic [CW-1:0] ONE_C     = CW'(1);

   logic [DATA_W-1:0]  regs_q [REG_NUM];
   logic [CW-1:0]      cnt    [REG_NUM];
   logic [REG_NUM-1:0] wr_sel;
   logic [REG_NUM-1:0] rel_sel;
   logic [REG_NUM-1:0] claim_sel;
   logic [REG_NUM-1:0] full;
   logic [REG_NUM-1:0] busy_vec;
   logic               wr_ok;
   logic               claim_err_q;
   logic               claim_err_d;

   // Decode: out-of-range writes select nothing, so their release is dropped too.
   always_comb begin
      wr_ok       = wrEn && ({1'b0, wrAddr} < REG_NUM_W);
      wr_sel      = '0;
      rel_sel     = '0;
      claim_sel   = '0;
      busy_vec    = '0;
      for (int r = 0; r < REG_NUM; r++) begin
         wr_sel[r]    = wr_ok && (wrAddr == AW'(r));
         rel_sel[r]   = wr_sel[r] && wrRelease;
         claim_sel[r] = claimEn && (claimAddr == AW'(r));
         busy_vec[r]  = rel_sel[r] ? (cnt[r] > ONE_C) : (cnt[r] != '0);
      end
      claim_err_d = |(claim_sel & full & ~rel_sel);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int r = 0; r < REG_NUM; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < REG_NUM; r++) begin
            if (wr_sel[r]) begin
               regs_q[r] <= wrData;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         claim_err_q <= 1'b0;
      end else begin
         claim_err_q <= claim_err_d;
      end
   end

   assign claimErr = claim_err_q;

   for (genvar g = 0; g < REG_NUM; g++) begin : g_cnt
      pend_counter #(
         .MAX (PEND_MAX),
         .CW  (CW)
      ) u_pend_counter (
         .CLK    (CLK),
         .RST    (RST),
         .inc_i  (claim_sel[g]),
         .dec_i  (rel_sel[g]),
         .cnt_o  (cnt[g]),
         .full_o (full[g])
      );
   end

   // Unmatched (out-of-range) read addresses fall through to data 0, busy 0.
   always_comb begin
      rdData1 = '0;
      rdData2 = '0;
      rdBusy1 = 1'b0;
      rdBusy2 = 1'b0;
      for (int r = 0; r < REG_NUM; r++) begin
         if (rdAddr1 == AW'(r)) begin
            rdData1 = wr_sel[r] ? wrData : regs_q[r];
            rdBusy1 = busy_vec[r];
         end
         if (rdAddr2 == AW'(r)) begin
            rdData2 = wr_sel[r] ? wrData : regs_q[r];
            rdBusy2 = busy_vec[r];
         end
      end
   end

   for (genvar g = 0; g < REG_NUM; g++) begin : g_dump
      assign dumpData[(REG_NUM-1-g)*DATA_W +: DATA_W] = regs_q[g];
   end

endmodule
